ovl_fire_collector: RTL and testbench

Downstream collector for the OVL checker fire pulses. It samples a vector of per-checker `fire` outputs on every clock. It keeps a saturating failure count per checker and a sticky first-failure record. It also queues time-stamped failure events into a small FIFO, which a monitor or trace port drains over a valid/ready handshake.

---
 rtl/ovl_fire_collector.sv | 165 ++++++++++++++++
 tb/tb_ovl_fire_collector.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ovl_fire_collector.sv
// ovl_fire_collector
//
// Collects the per-checker fire pulses of a bank of OVL checkers. For every
// accepted fire cycle it does three things:
//   - bumps a saturating failure counter for each checker that fired;
//   - records the first failing checker (sticky until reset);
//   - pushes one time-stamped event into a small FIFO drained by a consumer.
//
// Ports:
//   clock      : sole clock, rising edge
//   reset      : synchronous, active-high; clears all state
//   enable     : when low, fire is ignored (timestamp keeps running)
//   fire       : one bit per checker, high = checker failed this cycle
//   evt_ready  : consumer accepts the head event
//   evt_valid  : FIFO non-empty
//   evt_id     : lowest firing checker index of the head event
//   evt_time   : timestamp of the head event
//   evt_multi  : more than one checker fired in the head event's cycle
//   cnt_sel    : counter read select
//   cnt_value  : combinational read of counter cnt_sel (0 if out of range)
//   any_fail   : sticky, set by the first accepted fire
//   first_id   : checker index of the first accepted fire
//   overflow   : sticky, an event was dropped because the FIFO was full
//
// Event handshake: an event transfers on a rising edge where evt_valid and
// evt_ready are both high. While evt_valid is high and evt_ready is low the
// head event (evt_id/evt_time/evt_multi) is held stable. When evt_valid is
// low the event outputs read 0.

module ovl_fire_collector #(
    parameter int NUM_CHECKERS = 8,
    parameter int ID_WIDTH     = 3,
    parameter int CNT_WIDTH    = 8,
    parameter int TS_WIDTH     = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CHECKERS-1:0] fire,
    input  logic                    evt_ready,
    output logic                    evt_valid,
    output logic [ID_WIDTH-1:0]     evt_id,
    output logic [TS_WIDTH-1:0]     evt_time,
    output logic                    evt_multi,
    input  logic [ID_WIDTH-1:0]     cnt_sel,
    output logic [CNT_WIDTH-1:0]    cnt_value,
    output logic                    any_fail,
    output logic [ID_WIDTH-1:0]     first_id,
    output logic                    overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [TS_WIDTH-1:0]     r_ts;
    logic [CNT_WIDTH-1:0]    r_cnt        [NUM_CHECKERS];
    logic [ID_WIDTH-1:0]     r_fifo_id    [FIFO_DEPTH];
    logic [TS_WIDTH-1:0]     r_fifo_time  [FIFO_DEPTH];
    logic                    r_fifo_multi [FIFO_DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]          r_wr_ptr;
    logic [PTR_W:0]          r_rd_ptr;
    logic                    r_any_fail;
    logic [ID_WIDTH-1:0]     r_first_id;
    logic                    r_overflow;

    logic                    w_empty;
    logic                    w_full;
    logic                    w_accept;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic [ID_WIDTH-1:0]     w_low_id;
    logic [NUM_CHECKERS-1:0] w_fire_minus1;
    logic                    w_multi;
    logic [PTR_W-1:0]        w_wr_idx;
    logic [PTR_W-1:0]        w_rd_idx;

    assign w_wr_idx = r_wr_ptr[PTR_W-1:0];
    assign w_rd_idx = r_rd_ptr[PTR_W-1:0];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) && (w_wr_idx == w_rd_idx);

    assign w_accept = enable && (|fire);
    assign w_pop    = !w_empty && evt_ready;
    // A full FIFO still takes the new event if the head leaves on the same edge.
    assign w_push   = w_accept && (!w_full || w_pop);
    assign w_drop   = w_accept && w_full && !w_pop;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_fire_minus1 = fire - NUM_CHECKERS'(1);
    assign w_multi       = |(fire & w_fire_minus1);

    // Lowest set index: scan downward so the last hit is the lowest bit.
    always_comb begin
        w_low_id = '0;
        for (int i = NUM_CHECKERS - 1; i >= 0; i--) begin
            if (fire[i]) begin
                w_low_id = ID_WIDTH'(i);
            end
        end
    end

    // Counter read; selects with no matching checker fall through to 0.
    always_comb begin
        cnt_value = '0;
        for (int i = 0; i < NUM_CHECKERS; i++) begin
            if (cnt_sel == ID_WIDTH'(i)) begin
                cnt_value = r_cnt[i];
            end
        end
    end

    assign evt_valid = !w_empty;
    assign evt_id    = w_empty ? '0 : r_fifo_id[w_rd_idx];
    assign evt_time  = w_empty ? '0 : r_fifo_time[w_rd_idx];
    assign evt_multi = w_empty ? 1'b0 : r_fifo_multi[w_rd_idx];
    assign any_fail  = r_any_fail;
    assign first_id  = r_first_id;
    assign overflow  = r_overflow;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ts       <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_any_fail <= 1'b0;
            r_first_id <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < NUM_CHECKERS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_ts <= r_ts + TS_WIDTH'(1);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (PTR_W + 1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (PTR_W + 1)'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_accept && !r_any_fail) begin
                r_any_fail <= 1'b1;
                r_first_id <= w_low_id;
            end
            for (int i = 0; i < NUM_CHECKERS; i++) begin
                if (w_accept && fire[i] && (r_cnt[i] != '1)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Payload storage needs no reset; it is only visible behind evt_valid.
    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_fifo_id[w_wr_idx]    <= w_low_id;
            r_fifo_time[w_wr_idx]  <= r_ts;
            r_fifo_multi[w_wr_idx] <= w_multi;
        end
    end

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Testbench for ovl_fire_collector: directed test-plan phases with literal
// expectations, then randomized traffic, all compared each cycle against a
// queue-based behavioural model.

module tb_ovl_fire_collector;

    localparam int N     = 8;
    localparam int IDW   = 3;
    localparam int CW    = 8;
    localparam int TSW   = 16;
    localparam int DEPTH = 4;
    localparam int EW    = IDW + TSW + 1;

    logic           clock;
    logic           reset;
    logic           enable;
    logic [N-1:0]   fire;
    logic           evt_ready;
    logic           evt_valid;
    logic [IDW-1:0] evt_id;
    logic [TSW-1:0] evt_time;
    logic           evt_multi;
    logic [IDW-1:0] cnt_sel;
    logic [CW-1:0]  cnt_value;
    logic           any_fail;
    logic [IDW-1:0] first_id;
    logic           overflow;

    ovl_fire_collector #(
        .NUM_CHECKERS(N), .ID_WIDTH(IDW), .CNT_WIDTH(CW),
        .TS_WIDTH(TSW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .fire(fire),
        .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_id(evt_id),
        .evt_time(evt_time), .evt_multi(evt_multi), .cnt_sel(cnt_sel),
        .cnt_value(cnt_value), .any_fail(any_fail), .first_id(first_id),
        .overflow(overflow)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- scoreboard / model ----------------
    int total = 0;
    int bad   = 0;

    // Each queued event is {id, time, multi}.
    logic [EW-1:0]  exp_q[$];
    int             m_cnt[N];
    logic           m_any;
    logic [IDW-1:0] m_first;
    logic           m_ovf;
    logic [TSW-1:0] m_ts;
    logic           chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: advances on every rising edge from the inputs the DUT sees.
    logic           mp_pop;
    logic           mp_acc;
    int             mp_low;
    logic [EW-1:0]  mp_evt;
    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                exp_q.delete();
                for (int i = 0; i < N; i++) m_cnt[i] = 0;
                m_any   = 1'b0;
                m_first = '0;
                m_ovf   = 1'b0;
                m_ts    = '0;
                chk_on  = 1'b1;
            end else begin
                mp_pop = (exp_q.size() > 0) && evt_ready;
                mp_acc = enable && (fire != 0);
                if (mp_acc) begin
                    mp_low = -1;
                    for (int i = 0; i < N; i++) begin
                        if (fire[i]) begin
                            if (mp_low < 0) mp_low = i;
                            if (m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
                        end
                    end
                    mp_evt = {IDW'(mp_low), m_ts, ($countones(fire) > 1)};
                    if (!m_any) begin
                        m_any   = 1'b1;
                        m_first = IDW'(mp_low);
                    end
                end
                if (mp_pop) void'(exp_q.pop_front());
                if (mp_acc) begin
                    if ((exp_q.size() + (mp_pop ? 1 : 0)) < DEPTH || mp_pop) exp_q.push_back(mp_evt);
                    else m_ovf = 1'b1;
                end
                m_ts = m_ts + 16'd1;
            end
        end
    end

    // Compare process: every falling edge once reset has been seen.
    logic [EW-1:0] head;
    always @(negedge clock) begin
        if (chk_on) begin
            check("evt_valid", 32'(evt_valid), 32'(exp_q.size() > 0));
            head = (exp_q.size() > 0) ? exp_q[0] : '0;
            check("evt_id",    32'(evt_id),    32'(head[EW-1 -: IDW]));
            check("evt_time",  32'(evt_time),  32'(head[TSW:1]));
            check("evt_multi", 32'(evt_multi), 32'(head[0]));
            check("cnt_value", 32'(cnt_value), 32'(m_cnt[cnt_sel]));
            check("any_fail",  32'(any_fail),  32'(m_any));
            check("first_id",  32'(first_id),  32'(m_first));
            check("overflow",  32'(overflow),  32'(m_ovf));
        end
    end

    // ---------------- driver ----------------
    // Advance n rising edges; inputs changed afterwards apply at the next edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    logic [IDW-1:0] drain_ids[4];

    initial begin
        reset = 1'b1; enable = 1'b1; fire = '0; evt_ready = 1'b0; cnt_sel = '0;

        // Reset then idle: after 10 idle edges ts=10, so the next fire stamps 10.
        tick(2);
        reset = 1'b0;
        cnt_sel = 3'd2;
        tick(10);
        check("idle_valid", 32'(evt_valid), 32'd0);
        check("idle_any",   32'(any_fail),  32'd0);
        check("idle_ovf",   32'(overflow),  32'd0);

        // Single fire of checker 2.
        fire = 8'b0000_0100;
        tick(1);
        fire = '0;
        check("single_valid", 32'(evt_valid), 32'd1);
        check("single_id",    32'(evt_id),    32'd2);
        check("single_time",  32'(evt_time),  32'd10);
        check("single_multi", 32'(evt_multi), 32'd0);
        check("single_any",   32'(any_fail),  32'd1);
        check("single_first", 32'(first_id),  32'd2);
        check("single_cnt2",  32'(cnt_value), 32'd1);

        // Held while not ready.
        tick(2);
        check("hold_id", 32'(evt_id), 32'd2);

        // Multi-fire after draining the single event.
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        fire = 8'b1010_0000;
        tick(1);
        fire = '0;
        check("multi_id",    32'(evt_id),    32'd5);
        check("multi_multi", 32'(evt_multi), 32'd1);
        cnt_sel = 3'd5; #1;
        check("multi_cnt5",  32'(cnt_value), 32'd1);
        cnt_sel = 3'd7; #1;
        check("multi_cnt7",  32'(cnt_value), 32'd1);
        check("multi_first", 32'(first_id),  32'd2);

        // Overflow: five fires into an empty FIFO with no pops.
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            fire = N'(1) << (k + 1);
            tick(1);
        end
        fire = '0;
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head", 32'(evt_id),   32'd1);
        // Full with pop: head 1 leaves, checker 6 enters.
        fire = 8'b0100_0000;
        evt_ready = 1'b1;
        tick(1);
        fire = '0;
        drain_ids[0] = 3'd2; drain_ids[1] = 3'd3; drain_ids[2] = 3'd4; drain_ids[3] = 3'd6;
        for (int k = 0; k < 4; k++) begin
            check("drain_valid", 32'(evt_valid), 32'd1);
            check("drain_id",    32'(evt_id),    32'(drain_ids[k]));
            tick(1);
        end
        check("drain_empty", 32'(evt_valid), 32'd0);

        // Saturation on checker 0 from a fresh reset, then enable=0.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        cnt_sel = 3'd0;
        fire = 8'b0000_0001;
        tick(300);
        fire = '0;
        check("sat_cnt0",  32'(cnt_value), 32'd255);
        check("sat_first", 32'(first_id),  32'd0);
        tick(2);
        enable = 1'b0;
        fire = '1;
        tick(5);
        check("dis_valid", 32'(evt_valid), 32'd0);
        check("dis_cnt0",  32'(cnt_value), 32'd255);
        cnt_sel = 3'd4; #1;
        check("dis_cnt4",  32'(cnt_value), 32'd0);
        check("dis_first", 32'(first_id),  32'd0);
        fire = '0;
        enable = 1'b1;

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 199) == 0);
            enable    = ($urandom_range(0, 7) != 0);
            fire      = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            evt_ready = ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
            cnt_sel   = IDW'($urandom_range(0, N - 1));
            tick(1);
        end
        reset = 1'b0; fire = '0; evt_ready = 1'b0; enable = 1'b1;

        // Reset mid-drain: 4 queued with overflow, drain one, then reset.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            fire = N'(1) << k;
            tick(1);
        end
        fire = '0;
        evt_ready = 1'b1;
        tick(1);
        check("mid_valid_pre", 32'(evt_valid), 32'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        evt_ready = 1'b0;
        cnt_sel = 3'd1; #1;
        check("mid_valid", 32'(evt_valid), 32'd0);
        check("mid_ovf",   32'(overflow),  32'd0);
        check("mid_any",   32'(any_fail),  32'd0);
        check("mid_cnt1",  32'(cnt_value), 32'd0);

        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
